// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants for the FP issue scheduler.
//   Unit codes drive the writeback result mux (wb_unit).
//   Latencies are measured from accept to writeback.
//   SQRT_LAT is the longest latency, so it sets the depth of the slot array.
package fpu_pkg;

  localparam logic [2:0] UNIT_ADSB = 3'd0;
  localparam logic [2:0] UNIT_MULT = 3'd1;
  localparam logic [2:0] UNIT_CVRT = 3'd2;
  localparam logic [2:0] UNIT_SQRT = 3'd3;
  localparam logic [2:0] UNIT_LOAD = 3'd4;

  localparam int ADSB_LAT = 3;
  localparam int MULT_LAT = 2;
  localparam int CVRT_LAT = 2;
  localparam int LOAD_LAT = 2;
  localparam int SQRT_LAT = 8;

  localparam int SLOT_DEPTH = SQRT_LAT;
  localparam int SLOT_IDX_W = $clog2(SLOT_DEPTH);
  localparam int LAT_W      = $clog2(SLOT_DEPTH + 1);
  localparam int RD_W       = 5;
  localparam int UNIT_W     = 3;
  localparam int SLOT_W     = 1 + RD_W + UNIT_W + 1;

  typedef struct packed {
    logic              v;
    logic [RD_W-1:0]   rd;
    logic [UNIT_W-1:0] unit;
    logic              to_int;
  } wb_slot_t;

  function automatic logic [LAT_W-1:0] unit_lat(input logic [UNIT_W-1:0] unit);
    case (unit)
      UNIT_ADSB: unit_lat = LAT_W'(ADSB_LAT);
      UNIT_MULT: unit_lat = LAT_W'(MULT_LAT);
      UNIT_CVRT: unit_lat = LAT_W'(CVRT_LAT);
      UNIT_SQRT: unit_lat = LAT_W'(SQRT_LAT);
      UNIT_LOAD: unit_lat = LAT_W'(LOAD_LAT);
      default:   unit_lat = '0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_slots.sv
// fpu_wb_slots: writeback reservation shift register.
//   clk, rstn   clock, synchronous active-low reset
//   ins_en      write ins_slot into q[ins_idx] (overrides the shifted value)
//   query_lat   latency of the candidate op; query_busy = q[query_lat].v
//               (always 0 for latencies that are 0 or reach past the array)
//   head        q[0], the slot writing back this cycle
module fpu_wb_slots
  import fpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ins_en,
  input  logic [SLOT_IDX_W-1:0] ins_idx,
  input  wb_slot_t              ins_slot,
  input  logic [LAT_W-1:0]      query_lat,
  output logic                  query_busy,
  output wb_slot_t              head
);

  wb_slot_t q [SLOT_DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < SLOT_DEPTH; k++) q[k] <= '0;
    end else begin
      for (int k = 0; k < SLOT_DEPTH - 1; k++) q[k] <= q[k+1];
      q[SLOT_DEPTH-1] <= '0;
      if (ins_en) q[ins_idx] <= ins_slot;
    end
  end

  // q[L] now lands in q[L-1] next cycle, i.e. the same writeback cycle the new op wants.
  always_comb begin
    query_busy = 1'b0;
    for (int k = 1; k < SLOT_DEPTH; k++) begin
      if (query_lat == LAT_W'(k)) query_busy = q[k].v;
    end
  end

  assign head = q[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: in-order FP issue scheduler.
//   issue_valid/issue_ready  decode handshake (ready is combinational)
//   is_adsb..is_load         unit select, at most one high
//   reg_write, is_ftoi       destination is the FP file / integer file
//   use_rs1/use_rs2, rs1/rs2, rd  operand and destination indices
//   sqrt_start, sqrt_busy    sqrt unit control and status
//   wb_valid/wb_rd/wb_unit/wb_to_int  registered writeback to the FP regfile mux
module fpu_issue_sched
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        is_adsb,
  input  logic        is_mult,
  input  logic        is_cvrt,
  input  logic        is_sqrt,
  input  logic        is_load,
  input  logic        reg_write,
  input  logic        is_ftoi,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        sqrt_start,
  output logic        sqrt_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [2:0]  wb_unit,
  output logic        wb_to_int
);

  logic [31:0]           pend;
  logic [31:0]           pend_set;
  logic [31:0]           pend_clr;
  logic [LAT_W-1:0]      sqrt_cnt;
  logic [UNIT_W-1:0]     unit_sel;
  logic [LAT_W-1:0]      lat;
  logic [LAT_W-1:0]      lat_m1;
  logic                  has_unit;
  logic                  takes_slot;
  logic                  port_busy;
  logic                  fp_wb;
  logic                  raw1;
  logic                  raw2;
  logic                  waw;
  logic                  accept;
  logic                  ins_en;
  wb_slot_t              ins_slot;
  wb_slot_t              head;

  always_comb begin
    unit_sel = UNIT_ADSB;
    if (is_mult)      unit_sel = UNIT_MULT;
    else if (is_cvrt) unit_sel = UNIT_CVRT;
    else if (is_sqrt) unit_sel = UNIT_SQRT;
    else if (is_load) unit_sel = UNIT_LOAD;
  end

  assign has_unit   = is_adsb | is_mult | is_cvrt | is_sqrt | is_load;
  // Ops writing nowhere (or with no unit) never reach the writeback port.
  assign takes_slot = has_unit & (reg_write | is_ftoi);
  assign lat        = unit_lat(unit_sel);
  assign lat_m1     = lat - LAT_W'(1);

  // Regfile is write-through, so a result writing back this cycle satisfies a read.
  assign fp_wb = head.v & ~head.to_int;
  assign raw1  = use_rs1 & pend[rs1] & ~(fp_wb & (head.rd == rs1));
  assign raw2  = use_rs2 & pend[rs2] & ~(fp_wb & (head.rd == rs2));
  assign waw   = takes_slot & reg_write & ~is_ftoi & pend[rd];

  assign sqrt_busy   = (sqrt_cnt != '0);
  assign issue_ready = rstn & ~raw1 & ~raw2 & ~waw & ~(takes_slot & port_busy)
                     & ~(takes_slot & is_sqrt & sqrt_busy);
  assign accept      = issue_valid & issue_ready;
  assign ins_en      = accept & takes_slot;
  assign sqrt_start  = ins_en & is_sqrt;

  always_comb begin
    ins_slot        = '0;
    ins_slot.v      = 1'b1;
    ins_slot.rd     = rd;
    ins_slot.unit   = unit_sel;
    ins_slot.to_int = is_ftoi;
  end

  fpu_wb_slots u_slots (
    .clk        (clk),
    .rstn       (rstn),
    .ins_en     (ins_en),
    .ins_idx    (lat_m1[SLOT_IDX_W-1:0]),
    .ins_slot   (ins_slot),
    .query_lat  (lat),
    .query_busy (port_busy),
    .head       (head)
  );

  assign pend_set = (ins_en & reg_write & ~is_ftoi) ? (32'd1 << rd) : 32'd0;
  assign pend_clr = fp_wb ? (32'd1 << head.rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend     <= '0;
      sqrt_cnt <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (sqrt_start)
        sqrt_cnt <= LAT_W'(SQRT_LAT - 1);
      else if (sqrt_busy)
        sqrt_cnt <= sqrt_cnt - LAT_W'(1);
    end
  end

  assign wb_valid  = head.v;
  assign wb_rd     = head.rd;
  assign wb_unit   = head.unit;
  assign wb_to_int = head.to_int;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Testbench for fpu_issue_sched: directed op sequences, a reservation-table
// model checked every cycle, plus literal accept/writeback cycle expectations.
module tb_fpu_issue_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic       is_adsb = 1'b0, is_mult = 1'b0, is_cvrt = 1'b0, is_sqrt = 1'b0, is_load = 1'b0;
  logic       reg_write = 1'b0, is_ftoi = 1'b0, use_rs1 = 1'b0, use_rs2 = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       sqrt_start, sqrt_busy, wb_valid, wb_to_int;
  logic [4:0] wb_rd;
  logic [2:0] wb_unit;

  always #5 clk = ~clk;

  fpu_issue_sched dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .is_adsb(is_adsb), .is_mult(is_mult), .is_cvrt(is_cvrt), .is_sqrt(is_sqrt),
    .is_load(is_load), .reg_write(reg_write), .is_ftoi(is_ftoi),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .sqrt_start(sqrt_start), .sqrt_busy(sqrt_busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_unit(wb_unit), .wb_to_int(wb_to_int)
  );

  typedef struct {
    int rd;
    int unit;
    bit to_int;
  } exp_wb_t;

  exp_wb_t wbq [int];        // expected writeback keyed by cycle number
  int      last_sqrt = -100; // cycle of the last accepted sqrt
  int      last_wb_cyc [32];
  int      last_int_wb = -1;
  int      wb_count = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  int      cyc = 0;
  bit      chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unit_code();
    if (is_adsb) return 0;
    if (is_mult) return 1;
    if (is_cvrt) return 2;
    if (is_sqrt) return 3;
    if (is_load) return 4;
    return -1;
  endfunction

  function automatic int lat_of(input int u);
    case (u)
      0: return 3;
      1: return 2;
      2: return 2;
      3: return 8;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  // A register is outstanding if an FP-file writeback for it is due at or after 'from'.
  function automatic bit pending_fp(input int r, input int from);
    foreach (wbq[k]) if (k >= from && !wbq[k].to_int && wbq[k].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : cmp
    int      c, u, lat;
    bit      e_wbv, busy, takes, stall, e_ready;
    exp_wb_t e, ent;
    if (chk_en) begin
      c     = cyc;
      e_wbv = wbq.exists(c);
      if (e_wbv) e = wbq[c];
      else begin e.rd = 0; e.unit = 0; e.to_int = 1'b0; end
      busy  = (c > last_sqrt) && (c < last_sqrt + 8);
      u     = unit_code();
      lat   = lat_of(u);
      takes = (u >= 0) && (reg_write || is_ftoi);
      stall = (use_rs1 && pending_fp(rs1, c + 1)) ||
              (use_rs2 && pending_fp(rs2, c + 1)) ||
              (takes && reg_write && !is_ftoi && pending_fp(rd, c)) ||
              (takes && lat < 8 && wbq.exists(c + lat)) ||
              (takes && is_sqrt && busy);
      e_ready = rstn && !stall;

      check("wb_valid", int'(wb_valid), int'(e_wbv));
      check("wb_rd", int'(wb_rd), e.rd);
      check("wb_unit", int'(wb_unit), e.unit);
      check("wb_to_int", int'(wb_to_int), int'(e.to_int));
      check("sqrt_busy", int'(sqrt_busy), int'(busy));
      check("issue_ready", int'(issue_ready), int'(e_ready));
      check("sqrt_start", int'(sqrt_start),
            int'(issue_valid && e_ready && takes && is_sqrt));

      if (wb_valid) begin
        last_wb_cyc[wb_rd] = c;
        wb_count++;
        if (wb_to_int) last_int_wb = c;
      end

      if (!rstn) begin
        wbq.delete();
        last_sqrt = -100;
      end else if (issue_valid && e_ready && takes) begin
        ent.rd = int'(rd); ent.unit = u; ent.to_int = is_ftoi;
        wbq[c + lat] = ent;
        if (is_sqrt) last_sqrt = c;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a posedge; holds the op until accepted, returns the accept cycle.
  task automatic issue(input int unit, input bit rw, input bit ftoi,
                       input bit u1, input int r1, input bit u2, input int r2,
                       input int d, output int acc);
    is_adsb = (unit == 0); is_mult = (unit == 1); is_cvrt = (unit == 2);
    is_sqrt = (unit == 3); is_load = (unit == 4);
    reg_write = rw; is_ftoi = ftoi;
    use_rs1 = u1; rs1 = 5'(r1); use_rs2 = u2; rs2 = 5'(r2); rd = 5'(d);
    issue_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (issue_ready) acc = cyc;
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    {is_adsb, is_mult, is_cvrt, is_sqrt, is_load} = '0;
    {reg_write, is_ftoi, use_rs1, use_rs2} = '0;
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: unit %0d rd %0d never accepted", unit, d);
    end
  endtask

  initial begin
    int s, a0, a1, a2, wbc;
    for (int i = 0; i < 32; i++) last_wb_cyc[i] = -1;
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    chk_en = 1'b1;
    check("rst_wb_valid", int'(wb_valid), 0);
    check("rst_wb_rd", int'(wb_rd), 0);
    check("rst_sqrt_busy", int'(sqrt_busy), 0);
    idle(1);

    // 1: single adsb, latency 3, then rd 3 no longer pending
    s = cyc;
    issue(0, 1, 0, 0, 0, 0, 0, 3, a0);
    check("t1_acc", a0, s);
    idle(5);
    check("t1_wb_cyc", last_wb_cyc[3], s + 3);
    s = cyc;
    issue(1, 1, 0, 1, 3, 0, 0, 3, a0);
    check("t1_pend_clear", a0, s);
    idle(6);

    // 2: write-port collision between adsb and a following mult
    s = cyc;
    issue(0, 1, 0, 0, 0, 0, 0, 4, a0);
    issue(1, 1, 0, 0, 0, 0, 0, 5, a1);
    check("t2_acc_adsb", a0, s);
    check("t2_acc_mult", a1, s + 2);
    idle(6);
    check("t2_wb4", last_wb_cyc[4], s + 3);
    check("t2_wb5", last_wb_cyc[5], s + 4);

    // 3: RAW on mult result, released by bypass in its writeback cycle
    s = cyc;
    issue(1, 1, 0, 0, 0, 0, 0, 6, a0);
    issue(0, 1, 0, 1, 6, 0, 0, 11, a1);
    check("t3_acc_mult", a0, s);
    check("t3_acc_adsb", a1, s + 2);
    idle(6);
    check("t3_wb6", last_wb_cyc[6], s + 2);
    check("t3_wb11", last_wb_cyc[11], s + 5);

    // 4: back-to-back sqrt
    s = cyc;
    issue(3, 1, 0, 0, 0, 0, 0, 7, a0);
    issue(3, 1, 0, 0, 0, 0, 0, 8, a1);
    check("t4_acc_sqrt0", a0, s);
    check("t4_acc_sqrt1", a1, s + 8);
    idle(12);
    check("t4_wb7", last_wb_cyc[7], s + 8);
    check("t4_wb8", last_wb_cyc[8], s + 16);

    // 5: ftoi to a pending FP register is not a WAW; a real FP write is
    s = cyc;
    issue(3, 1, 0, 0, 0, 0, 0, 9, a0);
    issue(2, 0, 1, 0, 0, 0, 0, 9, a1);
    issue(1, 1, 0, 0, 0, 0, 0, 9, a2);
    check("t5_acc_sqrt", a0, s);
    check("t5_acc_ftoi", a1, s + 1);
    check("t5_acc_waw", a2, s + 9);
    idle(4);
    check("t5_int_wb", last_int_wb, s + 3);
    check("t5_wb9", last_wb_cyc[9], s + 11);
    idle(2);

    // 6: reset while a sqrt is in flight
    s = cyc;
    issue(3, 1, 0, 0, 0, 0, 0, 2, a0);
    check("t6_acc_sqrt", a0, s);
    idle(2);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    check("t6_cyc", cyc, s + 4);
    check("t6_sqrt_busy", int'(sqrt_busy), 0);
    wbc = wb_count;
    idle(12);
    check("t6_no_wb", wb_count, wbc);
    check("t6_wb2", last_wb_cyc[2], -1);
    s = cyc;
    issue(1, 1, 0, 1, 2, 0, 0, 2, a0);
    check("t6_pend_clear", a0, s);
    idle(4);
    check("t6_wb2_new", last_wb_cyc[2], s + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
